// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side streamer.
package fifo_rd_pkg;

    // Burst sequencing states.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    // Number of beats the skid buffer can hold.
    localparam int SKID_DEPTH = 2;
    // Width of the skid occupancy count (holds 0..SKID_DEPTH).
    localparam int SKID_CNT_W = $clog2(SKID_DEPTH + 1);

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer between the FIFO read port and the output stream.
// Entry 0 is the head and drives the stream. Push and pop may happen in the
// same cycle. When FIFO_RD_STREAMER_PARITY_EN is defined, a parity bit is
// stored next to each data word.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [W-1:0]          push_data,
`ifdef FIFO_RD_STREAMER_PARITY_EN
    input  logic                  push_parity,
    output logic                  head_parity,
`endif
    input  logic                  pop,
    output logic [W-1:0]          head_data,
    output logic [SKID_CNT_W-1:0] count
);

`ifdef FIFO_RD_STREAMER_PARITY_EN
    localparam int EW = W + 1;
`else
    localparam int EW = W;
`endif

    logic [EW-1:0] din;
    logic [EW-1:0] mem [SKID_DEPTH];

`ifdef FIFO_RD_STREAMER_PARITY_EN
    assign din         = {push_parity, push_data};
    assign head_data   = mem[0][W-1:0];
    assign head_parity = mem[0][W];
`else
    assign din         = push_data;
    assign head_data   = mem[0];
`endif

    // Shift-register FIFO: pops move entry 1 down to the head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: storage is reset here because the head entry is a visible output (m_data must read 0 out of reset).
            mem[0] <= '0;
            mem[1] <= '0;
            count  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == '0) mem[0] <= din;
                    else             mem[1] <= din;
                    count <= count + SKID_CNT_W'(1);
                end
                2'b01: begin
                    mem[0] <= mem[1];
                    count  <= count - SKID_CNT_W'(1);
                end
                2'b11: begin
                    if (count == SKID_CNT_W'(SKID_DEPTH)) begin
                        mem[0] <= mem[1];
                        mem[1] <= din;
                    end else begin
                        mem[0] <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_streamer.sv
// Read-side consumer of the synchronous FIFO: drains a requested burst and
// presents it on a valid/ready stream with a last-beat marker. The FIFO's
// one-cycle read latency and sink back-pressure are absorbed by a two-entry
// skid buffer. Optional parity output: FIFO_RD_STREAMER_PARITY_EN.
module fifo_rd_streamer
    import fifo_rd_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int MAX_BURST  = 256,
    parameter int CNT_W      = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
`ifdef FIFO_RD_STREAMER_PARITY_EN
    output logic                  m_parity,
`endif
    output logic                  err_underflow
);

    state_t                state;
    logic [CNT_W-1:0]      length;
    logic [CNT_W-1:0]      issued;
    logic [CNT_W-1:0]      sent;
    logic                  in_flight;
    logic [SKID_CNT_W-1:0] skid_count;
    logic [SKID_CNT_W:0]   occupancy;
    logic                  start_acc;
    logic                  pop;

    assign start_acc = start && (state == IDLE);
    assign m_valid   = (skid_count != '0);
    assign pop       = m_valid && m_ready;
    assign m_last    = m_valid && (sent == length - CNT_W'(1));

    // Words already committed to the skid buffer (stored or in flight), minus
    // the beat leaving this cycle, so a draining buffer can refill every cycle.
    assign occupancy = {1'b0, skid_count}
                     + {{SKID_CNT_W{1'b0}}, in_flight}
                     - {{SKID_CNT_W{1'b0}}, pop};

    assign fifo_rd_en = (state == RUN) && !fifo_empty && (issued < length)
                     && (occupancy < (SKID_CNT_W + 1)'(SKID_DEPTH));

    // Burst sequencing with registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (burst_len != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issued == length) state <= FLUSH;
                end
                FLUSH: begin
                    if (sent == length) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Latched burst length plus issued/sent counters, cleared on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            length <= '0;
            issued <= '0;
            sent   <= '0;
        end else if (start_acc) begin
            length <= burst_len;
            issued <= '0;
            sent   <= '0;
        end else begin
            if (fifo_rd_en) issued <= issued + CNT_W'(1);
            if (pop)        sent   <= sent + CNT_W'(1);
        end
    end

    // Read-in-flight tracking and the sticky underflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight     <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            in_flight <= fifo_rd_en;
            if (start_acc)      err_underflow <= 1'b0;
            if (fifo_underflow) err_underflow <= 1'b1;
        end
    end

    fifo_rd_skid #(
        .W (FIFO_WIDTH)
    ) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (in_flight),
        .push_data   (fifo_data_out),
`ifdef FIFO_RD_STREAMER_PARITY_EN
        .push_parity (^fifo_data_out),
        .head_parity (m_parity),
`endif
        .pop         (pop),
        .head_data   (m_data),
        .count       (skid_count)
    );

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Self-checking bench for fifo_rd_streamer. A queue-based FIFO drives the read
// port; a transaction-level model (expected word queue, beat counts, cycle
// stamps for busy/done) checks the outputs every cycle on the falling edge.
module tb_fifo_rd_streamer;

    localparam int W   = 16;
    localparam int CW  = 9;
    localparam int BIG = 32'h3fff_ffff;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          start = 1'b0;
    logic [CW-1:0] burst_len = '0;
    logic          busy, done, fifo_rd_en;
    logic [W-1:0]  fifo_data_out = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_underflow = 1'b0;
    logic          m_valid, m_last, err_underflow;
    logic [W-1:0]  m_data;
    logic          m_ready = 1'b0;
`ifdef FIFO_RD_STREAMER_PARITY_EN
    logic          m_parity;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Bench FIFO contents and the words the stream must deliver, in order.
    logic [W-1:0] fq[$];
    logic [W-1:0] sb[$];

    // Per-test logs written by the compare process.
    int           rd_cycles[$];
    int           beat_cycles[$];
    int           done_cycles[$];
    logic [W-1:0] beat_data[$];
    logic         beat_last[$];
    logic         beat_par[$];

    // Transaction model state.
    int           cyc = 0;
    int           busy_from = BIG, busy_to = -1, done_at = -1, idle_from = 0;
    int           mdl_len = 0, mdl_sent = 0, mdl_issued = 0;
    logic         err_mdl = 1'b0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic         prev_last = 1'b0;
    logic         exp_busy, hs;
    logic [W-1:0] exp_word;

    fifo_rd_streamer #(
        .FIFO_WIDTH (W),
        .MAX_BURST  (256)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .burst_len      (burst_len),
        .busy           (busy),
        .done           (done),
        .fifo_rd_en     (fifo_rd_en),
        .fifo_data_out  (fifo_data_out),
        .fifo_empty     (fifo_empty),
        .fifo_underflow (fifo_underflow),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_last         (m_last),
        .m_ready        (m_ready),
`ifdef FIFO_RD_STREAMER_PARITY_EN
        .m_parity       (m_parity),
`endif
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Synchronous FIFO with a registered read port.
    always @(posedge clk) begin
        if (fifo_rd_en && fq.size() != 0) begin
            fifo_data_out <= fq.pop_front();
            fifo_empty    <= (fq.size() == 0);
        end
    end

    // Compare process: checks every output against the model each cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            busy_from  = BIG;
            busy_to    = -1;
            done_at    = -1;
            idle_from  = 0;
            mdl_len    = 0;
            mdl_sent   = 0;
            mdl_issued = 0;
            err_mdl    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
            hs       = m_valid && m_ready;
            check("busy", busy, exp_busy);
            check("done", done, cyc == done_at);
            check("err_underflow", err_underflow, err_mdl);
            check("rd_en_while_empty", fifo_rd_en && fifo_empty, 0);
            if (fifo_rd_en)
                check("rd_en_allowed",
                      exp_busy && (mdl_issued < mdl_len) && (mdl_issued - mdl_sent - int'(hs) < 2), 1);
            if (prev_stall) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, prev_data);
                check("hold_last", m_last, prev_last);
            end
            if (m_valid) check("m_last", m_last, mdl_sent == mdl_len - 1);
            else         check("m_last_idle", m_last, 0);
`ifdef FIFO_RD_STREAMER_PARITY_EN
            if (m_valid) check("m_parity", m_parity, ^m_data);
`endif
            if (fifo_rd_en) rd_cycles.push_back(cyc);
            if (done) done_cycles.push_back(cyc);
            if (hs) begin
                check("beat_expected", sb.size() != 0, 1);
                exp_word = (sb.size() != 0) ? sb.pop_front() : '0;
                check("m_data", m_data, exp_word);
                beat_cycles.push_back(cyc);
                beat_data.push_back(m_data);
                beat_last.push_back(m_last);
`ifdef FIFO_RD_STREAMER_PARITY_EN
                beat_par.push_back(m_parity);
`endif
                mdl_sent++;
                if (mdl_sent == mdl_len) begin
                    busy_to   = cyc + 1;
                    done_at   = cyc + 2;
                    idle_from = cyc + 3;
                end
            end
            if (start && cyc >= idle_from) begin
                err_mdl    = 1'b0;
                mdl_len    = int'(burst_len);
                mdl_sent   = 0;
                mdl_issued = 0;
                if (burst_len == '0) begin
                    done_at   = cyc + 1;
                    idle_from = cyc + 2;
                end else begin
                    busy_from = cyc + 1;
                    busy_to   = BIG;
                    idle_from = BIG;
                end
            end
            if (fifo_underflow) err_mdl = 1'b1;
            if (fifo_rd_en) mdl_issued++;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [W-1:0] w);
        fq.push_back(w);
        sb.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_log();
        rd_cycles.delete();
        beat_cycles.delete();
        done_cycles.delete();
        beat_data.delete();
        beat_last.delete();
        beat_par.delete();
    endtask

    task automatic pulse_start(input int len);
        burst_len = CW'(len);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && done_cycles.size() == 0; i++) tick();
        check("done_seen", done_cycles.size(), 1);
        tick();
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int i = 0; i < budget && beat_cycles.size() < n; i++) tick();
        check("beats_seen", beat_cycles.size() >= n, 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stim
        int s0, n_stall;

        // Reset state.
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_err", err_underflow, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Basic 4-word burst with the sink always ready.
        clear_log();
        for (int i = 1; i <= 4; i++) load(W'(i));
        m_ready = 1'b1;
        pulse_start(4);
        wait_done(40);
        check("basic_rd_count", rd_cycles.size(), 4);
        check("basic_rd_b2b", rd_cycles[3] - rd_cycles[0], 3);
        check("basic_beats", beat_cycles.size(), 4);
        check("basic_beat_b2b", beat_cycles[3] - beat_cycles[0], 3);
        check("basic_last_data", beat_data[3], 16'h0004);
        check("basic_last_flag", beat_last[3], 1);
        check("basic_first_not_last", beat_last[0], 0);
        check("basic_done_delay", done_cycles[0] - beat_cycles[3], 2);

        // Back-pressure: sink stalls for 3 cycles after the 2nd beat.
        clear_log();
        for (int i = 1; i <= 8; i++) load(W'(i));
        pulse_start(8);
        wait_beats(2, 20);
        s0 = cyc;
        m_ready = 1'b0;
        repeat (3) tick();
        m_ready = 1'b1;
        wait_done(60);
        n_stall = 0;
        foreach (rd_cycles[i]) if (rd_cycles[i] >= s0 && rd_cycles[i] <= s0 + 2) n_stall++;
        check("bp_rd_during_stall", n_stall, 0);
        check("bp_rd_count", rd_cycles.size(), 8);
        check("bp_beats", beat_cycles.size(), 8);
        for (int i = 0; i < 8; i++) check($sformatf("bp_order%0d", i), beat_data[i], 32'(i + 1));

        // Starved FIFO: one word available, two more arrive later.
        clear_log();
        load(16'h0021);
        pulse_start(3);
        repeat (5) tick();
        load(16'h0022);
        load(16'h0023);
        wait_done(40);
        check("starve_beats", beat_cycles.size(), 3);
        check("starve_data2", beat_data[2], 16'h0023);
        check("starve_last", beat_last[2], 1);

        // Zero-length burst.
        clear_log();
        s0 = cyc;
        pulse_start(0);
        wait_done(10);
        check("zero_done_delay", done_cycles[0] - s0, 1);
        check("zero_no_rd", rd_cycles.size(), 0);

        // Start while busy is ignored.
        clear_log();
        for (int i = 0; i < 8; i++) load(W'(16'h0031 + i));
        pulse_start(8);
        repeat (3) tick();
        pulse_start(2);
        wait_done(60);
        repeat (5) tick();
        check("busy_start_beats", beat_cycles.size(), 8);
        check("busy_start_done_once", done_cycles.size(), 1);
        check("busy_start_fifo_drained", fq.size(), 0);
        check("busy_start_last", beat_last[7], 1);

        // Reset in the middle of a 6-word burst.
        clear_log();
        for (int i = 0; i < 6; i++) load(W'(16'h0041 + i));
        pulse_start(6);
        wait_beats(2, 20);
        #2 rst_n = 1'b0;
        fq.delete();
        fifo_empty = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_rd_en", fifo_rd_en, 0);
        check("mid_rst_m_valid", m_valid, 0);
        check("mid_rst_m_last", m_last, 0);
        check("mid_rst_m_data", m_data, 0);
        check("mid_rst_err", err_underflow, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_no_done", done_cycles.size(), 0);
        clear_log();
        load(16'h0051);
        load(16'h0052);
        pulse_start(2);
        wait_done(30);
        check("post_rst_beats", beat_cycles.size(), 2);
        check("post_rst_data1", beat_data[1], 16'h0052);
        check("post_rst_last", beat_last[1], 1);

        // Sticky underflow, cleared by the next accepted start; parity lane.
        clear_log();
        fifo_underflow = 1'b1;
        tick();
        fifo_underflow = 1'b0;
        repeat (3) tick();
        check("uf_sticky", err_underflow, 1);
        load(16'h0007);
        load(16'h0003);
        pulse_start(2);
        check("uf_cleared", err_underflow, 0);
        wait_done(30);
        check("par_beats", beat_cycles.size(), 2);
        check("par_data0", beat_data[0], 16'h0007);
`ifdef FIFO_RD_STREAMER_PARITY_EN
        check("par_0007", beat_par[0], 1);
        check("par_0003", beat_par[1], 0);
`endif

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
